// File: rtl/divider2_pkg.sv
// divider2_pkg: state encoding, default widths and counter sizing shared by the divider2 files.
package divider2_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int DEF_DVD_W = 16;
    localparam int DEF_DVS_W = 8;

    function automatic int cnt_w(input int dvd_w);
        return $clog2(dvd_w + 1);
    endfunction

endpackage

// File: rtl/divider2_step.sv
// divider2_step: one restoring-division step (shift in a dividend bit, compare, conditionally subtract).
module divider2_step
    import divider2_pkg::*;
#(
    parameter int DVS_W = DEF_DVS_W
) (
    input  logic [DVS_W-1:0] i_rem,
    input  logic             i_bit,
    input  logic [DVS_W-1:0] i_dvs,
    output logic [DVS_W-1:0] o_rem,
    output logic             o_q
);

    logic [DVS_W:0] w_part;

    assign w_part = {i_rem, i_bit};
    assign o_q    = w_part >= {1'b0, i_dvs};
    // a kept remainder is always below the divisor, so the difference fits in DVS_W bits
    assign o_rem  = o_q ? DVS_W'(w_part - {1'b0, i_dvs}) : w_part[DVS_W-1:0];

endmodule

// File: rtl/divider2.sv
// divider2: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define DIVIDER2_DBZ_EN to finish a divide-by-zero one edge after acceptance with dbz=1.
module divider2
    import divider2_pkg::*;
#(
    parameter int DVD_W = DEF_DVD_W,
    parameter int DVS_W = DEF_DVS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] Dividend,
    input  logic [DVS_W-1:0] Divisor,
    output logic [DVD_W-1:0] Quotient,
    output logic [DVS_W-1:0] Remainder,
    output logic             ready,
    output logic             dbz
);

    localparam int CW = cnt_w(DVD_W);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [DVD_W-1:0] r_dvd;
    logic [DVS_W-1:0] r_dvs;
    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] w_rem;
    logic             w_q;
    logic [DVD_W-1:0] w_dvd;

    divider2_step #(.DVS_W(DVS_W)) u_step (
        .i_rem(r_rem),
        .i_bit(r_dvd[DVD_W-1]),
        .i_dvs(r_dvs),
        .o_rem(w_rem),
        .o_q  (w_q)
    );

    // dividend bits leave at the top while quotient bits enter at the bottom
    assign w_dvd = {r_dvd[DVD_W-2:0], w_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            ready     <= 1'b0;
`ifdef DIVIDER2_DBZ_EN
            dbz       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_dvd   <= Dividend;
                        r_dvs   <= Divisor;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        ready   <= 1'b0;
`ifdef DIVIDER2_DBZ_EN
                        dbz     <= 1'b0;
`endif
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
`ifdef DIVIDER2_DBZ_EN
                    if (r_dvs == '0) begin
                        Quotient  <= '1;
                        Remainder <= r_dvd[DVS_W-1:0];
                        dbz       <= 1'b1;
                        ready     <= 1'b1;
                        r_state   <= DONE;
                    end else begin
`else
                    begin
`endif
                        r_dvd <= w_dvd;
                        r_rem <= w_rem;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(DVD_W - 1)) begin
                            Quotient  <= w_dvd;
                            Remainder <= w_rem;
                            ready     <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef DIVIDER2_DBZ_EN
    assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_divider2.sv
// tb_divider2: randomized scoreboard bench for divider2 against an arithmetic reference model.
module tb_divider2;

`ifdef DIVIDER2_DBZ_EN
    localparam bit DBZ = 1'b1;
`else
    localparam bit DBZ = 1'b0;
`endif

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] Dividend = '0;
    logic [7:0]  Divisor = '0;
    logic [15:0] Quotient;
    logic [7:0]  Remainder;
    logic        ready;
    logic        dbz;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic prev_ready = 1'b0;

    divider2 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .ready    (ready),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        int   ai = int'(a);
        int   bi = int'(b);
        e.q = (bi == 0) ? 16'hFFFF : 16'(ai / bi);
        e.r = (bi == 0) ? a[7:0] : 8'(ai % bi);
        e.d = (bi == 0) && DBZ;
        return e;
    endfunction

    always @(negedge clk) begin
        if (ready && !prev_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got Q=%0h R=%0h with no request pending", Quotient, Remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", Quotient, e.q);
                check("remainder", Remainder, e.r);
                check("dbz", dbz, e.d);
            end
        end
        prev_ready = ready;
    end

    // poke > 0 raises start with other operands so that it is sampled at edge E<poke>
    task automatic run(input logic [15:0] a, input logic [7:0] b, input int poke);
        int lat;
        int exp_lat;
        exp_lat = (DBZ && b == 0) ? 1 : 16;
        start = 1'b1;
        Dividend = a;
        Divisor = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        check("ready_low_after_accept", ready, 0);
        start = 1'b0;
        Dividend = 16'($urandom);
        Divisor = 8'($urandom);
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            if (n == poke) begin
                start = 1'b1;
                Dividend = ~a;
                Divisor = b + 8'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (ready) lat = n;
        end
        check("latency", lat, exp_lat);
    endtask

    initial begin
        #12;
        check("reset_quotient", Quotient, 0);
        check("reset_remainder", Remainder, 0);
        check("reset_ready", ready, 0);
        check("reset_dbz", dbz, 0);
        @(negedge clk);
        rst = 1'b0;
        run(16'd1000, 8'd7, 0);
        run(16'hFFFF, 8'hFF, 0);
        run(16'd5, 8'd9, 0);
        run(16'h1234, 8'd0, 0);
        run(16'd1000, 8'd7, 5);
        run(16'd2000, 8'd13, 16);
        repeat (3) @(posedge clk);
        #1;
        check("done_holds_ready", ready, 1);
        check("done_holds_quotient", Quotient, 16'd153);
        // abort mid-operation with an asynchronous reset
        start = 1'b1;
        Dividend = 16'd1000;
        Divisor = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_quotient", Quotient, 0);
        check("abort_remainder", Remainder, 0);
        check("abort_ready", ready, 0);
        check("abort_dbz", dbz, 0);
        @(negedge clk);
        rst = 1'b0;
        run(16'd1000, 8'd7, 0);
        for (int i = 0; i < 100; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run(16'(a) * 16'(b), b, 0);
            check("roundtrip_q", Quotient, 32'(a));
            check("roundtrip_r", Remainder, 0);
        end
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            run(16'($urandom), b, 0);
        end
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
